// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: a one-entry holding buffer feeds a shift engine
// that serialises start, 8 data bits (LSB first), optional parity and stop bits.
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       busy,
    output logic       txd
);

    localparam int             CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  CNT_MAX   = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     LAST_STOP = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t        state, state_next;
    logic [7:0]    buf_data;
    logic          buf_valid, buf_valid_next;
    logic [7:0]    shifter, shifter_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0]    bit_idx, bit_idx_next;
    logic          par_bit, par_bit_next;
    logic          txd_q, txd_next;
    logic          accept, load, bit_end;

    // in_ready comes straight from the buffer flag, so it never depends on in_valid
    assign in_ready = ~buf_valid;
    assign accept   = in_valid & ~buf_valid;
    assign busy     = (state != IDLE) | buf_valid;
    assign txd      = txd_q;
    assign bit_end  = (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_data <= '0;
        end else if (accept) begin
            buf_data <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            buf_valid <= 1'b0;
            shifter   <= '0;
            cnt       <= '0;
            bit_idx   <= '0;
            par_bit   <= 1'b0;
            txd_q     <= 1'b1;
        end else begin
            state     <= state_next;
            buf_valid <= buf_valid_next;
            shifter   <= shifter_next;
            cnt       <= cnt_next;
            bit_idx   <= bit_idx_next;
            par_bit   <= par_bit_next;
            txd_q     <= txd_next;
        end
    end

    always_comb begin
        state_next     = state;
        buf_valid_next = buf_valid;
        shifter_next   = shifter;
        cnt_next       = cnt;
        bit_idx_next   = bit_idx;
        par_bit_next   = par_bit;
        txd_next       = txd_q;
        load           = 1'b0;

        if (accept) begin
            buf_valid_next = 1'b1;
        end

        case (state)
            IDLE: begin
                txd_next = 1'b1;
                load     = buf_valid;
            end
            START: begin
                if (bit_end) begin
                    txd_next     = shifter[0];
                    bit_idx_next = '0;
                    cnt_next     = CNT_MAX;
                    state_next   = DATA;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_next = CNT_MAX;
                    if (bit_idx == 3'd7) begin
                        bit_idx_next = '0;
                        if (PARITY != 0) begin
                            txd_next   = par_bit;
                            state_next = PAR;
                        end else begin
                            txd_next   = 1'b1;
                            state_next = STOP;
                        end
                    end else begin
                        shifter_next = {1'b0, shifter[7:1]};
                        txd_next     = shifter[1];
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            PAR: begin
                if (bit_end) begin
                    txd_next     = 1'b1;
                    cnt_next     = CNT_MAX;
                    bit_idx_next = '0;
                    state_next   = STOP;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_idx == LAST_STOP) begin
                        // A waiting byte starts immediately so frames run gapless
                        if (buf_valid) begin
                            load = 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                        cnt_next     = CNT_MAX;
                    end
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                txd_next   = 1'b1;
            end
        endcase

        if (load) begin
            shifter_next   = buf_data;
            par_bit_next   = (PARITY == 2) ? ~(^buf_data) : (^buf_data);
            buf_valid_next = 1'b0;
            txd_next       = 1'b0;
            cnt_next       = CNT_MAX;
            bit_idx_next   = '0;
            state_next     = START;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: three instances cover 8N1, even
// parity with two stops, and odd parity; instance 0 is also scoreboarded.
module tb_uart_tx_buffered;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data  [3];
    logic       in_valid [3];
    logic       in_ready [3];
    logic       busy     [3];
    logic       txd      [3];

    int pass_checks  = 0;
    int total_checks = 0;
    int cyc          = 0;
    int frames_seen  = 0;
    bit mon_active   = 1'b0;

    logic [7:0] exp_q[$];
    int         start_times[$];

    typedef struct {
        int          inst;
        logic [7:0]  data;
        logic [11:0] bits;
        int          nbits;
    } vec_t;

    vec_t vecs [9];

    uart_tx_buffered #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .busy(busy[0]), .txd(txd[0])
    );
    uart_tx_buffered #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .busy(busy[1]), .txd(txd[1])
    );
    uart_tx_buffered #(.CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) dut2 (
        .clk(clk), .rst(rst), .in_data(in_data[2]), .in_valid(in_valid[2]),
        .in_ready(in_ready[2]), .busy(busy[2]), .txd(txd[2])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [2:0] get_out(input int i);
        return {txd[i], in_ready[i], busy[i]};
    endfunction

    task automatic check_val(input string name, input logic [15:0] act, input logic [15:0] exp);
        total_checks++;
        if (act === exp) begin
            pass_checks++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic applyStimulus(input int inst, input logic [7:0] d, output bit ok);
        int w = 0;
        in_data[inst]  = d;
        in_valid[inst] = 1'b1;
        while (in_ready[inst] !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        ok = (w < 200);
        if (ok) begin
            @(posedge clk);
            if (inst == 0) exp_q.push_back(d);
        end
        @(negedge clk);
        in_valid[inst] = 1'b0;
    endtask

    task automatic checkOutput(input int inst, input logic [11:0] bits, input int nbits,
                               input string tag);
        logic [11:0] act = '0;
        int          errs = 0;
        logic        ready0 = 1'b0;
        logic        busy_last = 1'b0;
        logic        samp;
        check_val({tag, "_accept"}, 16'(get_out(inst)), 16'(3'b101));
        for (int s = 0; s < nbits * 4; s++) begin
            @(negedge clk);
            samp = txd[inst];
            if (s == 0) ready0 = in_ready[inst];
            if (s % 4 == 2) act[s / 4] = samp;
            if (samp !== bits[s / 4]) errs++;
            busy_last = busy[inst];
        end
        check_val({tag, "_frame"}, 16'(act), 16'(bits));
        check_val({tag, "_timing"}, 16'(errs), 16'd0);
        check_val({tag, "_ready_after_load"}, 16'(ready0), 16'd1);
        @(negedge clk);
        check_val({tag, "_end"}, 16'({busy_last, get_out(inst)}), 16'(4'b1110));
    endtask

    task automatic waitDrain(input string tag);
        int w = 0;
        while ((exp_q.size() != 0 || mon_active || busy[0] !== 1'b0) && w < 1000) begin
            @(negedge clk);
            w++;
        end
        check_val({tag, "_drain"}, 16'(w < 1000), 16'd1);
    endtask

    // Scoreboard monitor for instance 0: decodes every frame seen on txd
    initial begin : monitor0
        logic [7:0] exp_byte;
        logic [9:0] exp_frame;
        logic [9:0] act_frame;
        int         errs;
        bit         aborted;
        bit         have;
        logic       samp;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && txd[0] === 1'b0) begin
                mon_active = 1'b1;
                start_times.push_back(cyc);
                have = (exp_q.size() != 0);
                if (have) begin
                    exp_byte = exp_q.pop_front();
                end else begin
                    exp_byte = 8'h00;
                    total_checks++;
                    $display("[TB] FAIL sb_unexpected_frame: got a frame, expected none queued");
                end
                exp_frame = {1'b1, exp_byte, 1'b0};
                act_frame = '0;
                errs      = 0;
                aborted   = 1'b0;
                for (int s = 0; s < 40; s++) begin
                    if (s > 0) @(negedge clk);
                    if (rst !== 1'b0) begin
                        aborted = 1'b1;
                        break;
                    end
                    samp = txd[0];
                    if (s % 4 == 2) act_frame[s / 4] = samp;
                    if (samp !== exp_frame[s / 4]) errs++;
                end
                if (!aborted) begin
                    frames_seen++;
                    if (have) begin
                        check_val("sb_frame", 16'(act_frame), 16'(exp_frame));
                        check_val("sb_timing", 16'(errs), 16'd0);
                    end
                end
                mon_active = 1'b0;
            end
        end
    end

    initial begin : main
        bit   ok;
        int   bad [3];
        int   n;
        int   acc;
        int   base;
        logic rdy;

        vecs[0] = '{0, 8'h55, 12'h2AA, 10};
        vecs[1] = '{0, 8'h00, 12'h200, 10};
        vecs[2] = '{0, 8'hFF, 12'h3FE, 10};
        vecs[3] = '{1, 8'h07, 12'hE0E, 12};
        vecs[4] = '{1, 8'h00, 12'hC00, 12};
        vecs[5] = '{1, 8'hFF, 12'hDFE, 12};
        vecs[6] = '{2, 8'h07, 12'h40E, 11};
        vecs[7] = '{2, 8'h00, 12'h600, 11};
        vecs[8] = '{2, 8'h80, 12'h500, 11};

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data[i]  = 8'h00;
            in_valid[i] = 1'b0;
        end

        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("reset_state%0d", i), 16'(get_out(i)), 16'(3'b110));
        end
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 3; i++) bad[i] = 0;
        repeat (20) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (get_out(i) !== 3'b110) bad[i]++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("idle%0d", i), 16'(bad[i]), 16'd0);
        end

        for (int v = 0; v < 9; v++) begin
            applyStimulus(vecs[v].inst, vecs[v].data, ok);
            check_val($sformatf("vec%0d_accepted", v), 16'(ok), 16'd1);
            checkOutput(vecs[v].inst, vecs[v].bits, vecs[v].nbits, $sformatf("vec%0d", v));
        end
        waitDrain("table");

        $display("[TB] back-to-back 0xA5, 0x3C");
        start_times.delete();
        applyStimulus(0, 8'hA5, ok);
        applyStimulus(0, 8'h3C, ok);
        check_val("b2b_second_accepted", 16'(ok), 16'd1);
        n = 0;
        while (in_ready[0] === 1'b0 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check_val("b2b_holdoff", 16'(n), 16'd39);
        waitDrain("b2b");
        check_val("b2b_frames", 16'(start_times.size()), 16'd2);
        if (start_times.size() >= 2) begin
            check_val("b2b_gap", 16'(start_times[1] - start_times[0]), 16'd40);
        end

        $display("[TB] reset during DATA with a byte buffered");
        applyStimulus(0, 8'hFF, ok);
        applyStimulus(0, 8'h11, ok);
        repeat (8) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_val("rst_async", 16'(get_out(0)), 16'(3'b110));
        exp_q.delete();
        @(negedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        bad[0] = 0;
        repeat (60) begin
            @(negedge clk);
            if (txd[0] !== 1'b1 || busy[0] !== 1'b0) bad[0]++;
        end
        check_val("rst_no_residual", 16'(bad[0]), 16'd0);

        $display("[TB] in_valid held with changing in_data");
        base = frames_seen;
        acc  = 0;
        in_valid[0] = 1'b1;
        for (int k = 0; k < 150; k++) begin
            in_data[0] = 8'(k * 37 + 5);
            rdy = in_ready[0];
            @(posedge clk);
            if (rdy) begin
                exp_q.push_back(in_data[0]);
                acc++;
            end
            @(negedge clk);
        end
        in_valid[0] = 1'b0;
        waitDrain("hold");
        check_val("hold_frame_count", 16'(frames_seen - base), 16'(acc));

        $display("%0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end

endmodule
